// File: rtl/cpu.sv
// -----------------------------------------------------------------------------
// cpu -- single-cycle 16-bit CPU subset (ADD, WWD, ADI, LHI, JMP)
//
// Each clk period retires one instruction. The fetch is split across two
// timing domains: clk commits the previously latched instruction and raises
// readM for the next one. A rising edge of the memory's inputReady pulse then
// latches the instruction word, counts it and applies any WWD output.
//
// Ports:
//   clk          system clock (commit / fetch request on rising edge)
//   reset_n      asynchronous active-low reset
//   readM        instruction-fetch request, address = PC
//   address      memory address (always the PC)
//   data         memory data bus, only read by the cpu (driven high-Z here)
//   inputReady   memory strobe; rising edge latches data while readM = 1
//   num_inst     number of instructions fetched since reset (wraps)
//   output_port  value written by the most recent WWD
//
// Configuration macro:
//   CPU_UNDEF_HALT_EN  defined: an unsupported instruction halts the CPU
//                      until reset. Undefined: it executes as a NOP.
// -----------------------------------------------------------------------------
module cpu #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 readM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic [WORD_SIZE-1:0] output_port
);

  localparam logic [3:0] OP_RTYPE = 4'd15;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [5:0] FN_ADD   = 6'd0;
  localparam logic [5:0] FN_WWD   = 6'd28;

`ifdef CPU_UNDEF_HALT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  // The cpu never drives the bus.
  assign data = {WORD_SIZE{1'bz}};

  // ---------------------------------------------------------------------------
  // Architectural state
  // ---------------------------------------------------------------------------
  logic [WORD_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] regs [4];
  logic [WORD_SIZE-1:0] instr;
  logic                 halted;

  // NOTE: readM and "instruction latched" are each set in one clock domain and
  // cleared in the other. Rather than driving one flop from two always blocks,
  // each domain owns a toggle and the flags are the XOR of two toggles.
  logic req_tgl;     // clk domain: flips when a fetch is requested
  logic ack_tgl;     // inputReady domain: flips when an instruction is latched
  logic commit_tgl;  // clk domain: flips when the latched instruction is consumed
  logic latched;

  assign readM   = req_tgl ^ ack_tgl;
  assign latched = ack_tgl ^ commit_tgl;
  assign address = pc;

  // ---------------------------------------------------------------------------
  // Decode / execute of the latched instruction
  // ---------------------------------------------------------------------------
  logic [3:0]           opcode;
  logic [1:0]           rs, rt, rd;
  logic [5:0]           func;
  logic [7:0]           imm;
  logic [11:0]          target;
  logic [WORD_SIZE-1:0] imm_sext;

  assign opcode   = instr[15:12];
  assign rs       = instr[11:10];
  assign rt       = instr[9:8];
  assign rd       = instr[7:6];
  assign func     = instr[5:0];
  assign imm      = instr[7:0];
  assign target   = instr[11:0];
  assign imm_sext = {{(WORD_SIZE-8){imm[7]}}, imm};

  logic [WORD_SIZE-1:0] next_pc;
  logic                 wr_en;
  logic [1:0]           wr_addr;
  logic [WORD_SIZE-1:0] wr_data;
  logic                 undef;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case statement leaves a value held, which would be a latch.
    next_pc = pc + 1'b1;
    wr_en   = 1'b0;
    wr_addr = rt;
    wr_data = '0;
    undef   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (func == FN_ADD) begin
          wr_en   = 1'b1;
          wr_addr = rd;
          wr_data = regs[rs] + regs[rt];
        end else if (func != FN_WWD) begin
          undef = 1'b1;
        end
      end
      OP_ADI: begin
        wr_en   = 1'b1;
        wr_data = regs[rs] + imm_sext;
      end
      OP_LHI: begin
        wr_en   = 1'b1;
        wr_data = {imm, 8'h00};
      end
      OP_JMP:  next_pc = {pc[WORD_SIZE-1:12], target};
      default: undef = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // clk domain: commit the latched instruction, then request the next one.
  // When nothing is latched and no fetch is outstanding (first edge after
  // reset), only the fetch of address PC is started.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc         <= '0;
      req_tgl    <= 1'b0;
      commit_tgl <= 1'b0;
      halted     <= 1'b0;
      // NOTE: the register file is four flops per bit, not a RAM macro, and
      // must read zero after reset, so it is cleared here like any other state.
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (latched) begin
      commit_tgl <= ~commit_tgl;
      if (HALT_EN && undef) begin
        halted <= 1'b1;
      end else begin
        if (wr_en) regs[wr_addr] <= wr_data;
        pc      <= next_pc;
        req_tgl <= ~req_tgl;
      end
    end else if (!readM && !halted) begin
      req_tgl <= ~req_tgl;
    end
  end

  // ---------------------------------------------------------------------------
  // inputReady domain: latch the instruction word while a fetch is pending.
  // WWD reads the register file here, which already holds the result of the
  // previous commit, so output_port is settled before the next clk edge.
  // ---------------------------------------------------------------------------
  logic is_wwd;
  assign is_wwd = (data[15:12] == OP_RTYPE) && (data[5:0] == FN_WWD);

  always_ff @(posedge inputReady or negedge reset_n) begin
    if (!reset_n) begin
      instr       <= '0;
      ack_tgl     <= 1'b0;
      num_inst    <= '0;
      output_port <= '0;
    end else if (readM) begin
      instr    <= data;
      ack_tgl  <= ~ack_tgl;
      num_inst <= num_inst + 1'b1;
      if (is_wwd) output_port <= regs[data[11:10]];
    end
  end

endmodule

// File: tb/tb_cpu.sv
// -----------------------------------------------------------------------------
// tb_cpu -- self-checking bench for cpu.
// A directed program exercises LHI/WWD/ADI/ADD/JMP and an unsupported
// instruction, followed by a mid-fetch reset and several rounds of random
// programs. Expected values come from an instruction-level model of the ISA.
// Build with the same CPU_UNDEF_HALT_EN setting as the RTL.
// -----------------------------------------------------------------------------
module tb_cpu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        inputReady = 1'b0;
  logic [15:0] data_drv = '0;
  wire  [15:0] data;
  logic        readM;
  logic [15:0] address;
  logic [15:0] num_inst;
  logic [15:0] output_port;

  assign data = data_drv;

  cpu #(.WORD_SIZE(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .readM       (readM),
    .address     (address),
    .data        (data),
    .inputReady  (inputReady),
    .num_inst    (num_inst),
    .output_port (output_port)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mem [4096];

  // Instruction-level reference model
  logic [15:0] r_m [4];
  logic [15:0] pc_m, ninst_m, out_m;
  bit          halt_m;
  bit          directed;
  bit          hit_17_20;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) r_m[i] = '0;
    pc_m = '0; ninst_m = '0; out_m = '0; halt_m = 0;
  endtask

  task automatic model_exec(input logic [15:0] i);
    int op, rs, rt, rd, fn, simm;
    logic bad;
    op = int'(i[15:12]); rs = int'(i[11:10]); rt = int'(i[9:8]);
    rd = int'(i[7:6]);   fn = int'(i[5:0]);
    simm = int'(i[7:0]);
    if (simm > 127) simm = simm - 256;
    bad = 0;
    ninst_m = ninst_m + 16'd1;
    if (op == 15 && fn == 0)       r_m[rd] = 16'((int'(r_m[rs]) + int'(r_m[rt])) % 65536);
    else if (op == 15 && fn == 28) out_m = r_m[rs];
    else if (op == 4)              r_m[rt] = 16'((int'(r_m[rs]) + simm + 65536) % 65536);
    else if (op == 6)              r_m[rt] = 16'(int'(i[7:0]) * 256);
    else if (op != 9)              bad = 1;
`ifdef CPU_UNDEF_HALT_EN
    if (bad) begin
      halt_m = 1;
      return;
    end
`endif
    if (op == 9) pc_m = 16'((int'(pc_m) / 4096) * 4096 + int'(i[11:0]));
    else         pc_m = 16'((int'(pc_m) + 1) % 65536);
  endtask

  // One clk period: on the edge the DUT commits and requests; memory answers
  // with an inputReady pulse; outputs are compared at the falling edge.
  task automatic bus_cycle();
    @(posedge clk); #1;
    if (!halt_m) begin
      check("readM", {15'b0, readM}, 16'd1);
      check("address", address, pc_m);
      if (directed && address >= 16'd17 && address <= 16'd20) hit_17_20 = 1;
      data_drv = mem[address[11:0]];
      #1 inputReady = 1'b1;
      #1 inputReady = 1'b0;
      model_exec(mem[pc_m[11:0]]);
    end else begin
      check("readM_halted", {15'b0, readM}, 16'd0);
      check("address_halted", address, pc_m);
      #1 inputReady = 1'b1;
      #1 inputReady = 1'b0;
    end
    @(negedge clk);
    check("num_inst", num_inst, ninst_m);
    check("output_port", output_port, out_m);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_readM", {15'b0, readM}, 16'd0);
    check("rst_address", address, 16'd0);
    check("rst_num_inst", num_inst, 16'd0);
    check("rst_output_port", output_port, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [15:0] gen_instr();
    logic [15:0] rnd;
    int k;
    rnd = 16'($urandom);
    k = int'($urandom_range(0, 39));
    if (k < 12)      return {4'hF, rnd[11:6], 6'd0};
    else if (k < 20) return {4'hF, rnd[11:6], 6'd28};
    else if (k < 27) return {4'h4, rnd[11:0]};
    else if (k < 34) return {4'h6, rnd[11:0]};
    else if (k < 37) return {4'h9, rnd[11:0]};
    else if (k < 39) return {4'hF, rnd[11:6], 6'd0};
    else             return {4'hF, rnd[11:6], 6'h3F};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed program
    for (int i = 0; i < 4096; i++) mem[i] = 16'hF03F;
    mem[0]  = 16'h6000; mem[1]  = 16'h6101; mem[2]  = 16'h6202; mem[3]  = 16'h6303;
    mem[4]  = 16'hF01C; mem[5]  = 16'hF41C; mem[6]  = 16'hF81C; mem[7]  = 16'hFC1C;
    mem[8]  = 16'h4204; mem[9]  = 16'h47FC; mem[10] = 16'hF81C; mem[11] = 16'hFC1C;
    mem[12] = 16'hF6C0; mem[13] = 16'hF180; mem[14] = 16'hF81C; mem[15] = 16'hFC1C;
    mem[16] = 16'h9015;
    mem[21] = 16'h6000; mem[22] = 16'h4000; mem[23] = 16'hFD80;
    mem[24] = 16'hF01C; mem[25] = 16'hF41C; mem[26] = 16'hF81C; mem[27] = 16'hFC1C;
    mem[28] = 16'hF03F; mem[29] = 16'hF81C; mem[30] = 16'h901E;

    // Held in reset across clock edges
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_readM", {15'b0, readM}, 16'd0);
    check("init_address", address, 16'd0);
    check("init_num_inst", num_inst, 16'd0);
    check("init_output_port", output_port, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;

    directed = 1; hit_17_20 = 0;
    for (int c = 0; c < 32; c++) begin
      bus_cycle();
      if (ninst_m == 16'd8)  check("wwd3_lhi", output_port, 16'd768);
      if (ninst_m == 16'd12) check("wwd3_adi_neg", output_port, 16'd252);
      if (ninst_m == 16'd16) check("wwd3_add", output_port, 16'd260);
      if (ninst_m == 16'd17) check("jump_count", num_inst, 16'd17);
      if (ninst_m == 16'd18) check("jump_target_fetched", pc_m, 16'd22);
      if (ninst_m == 16'd23) check("wwd2_after_jump", output_port, 16'd516);
    end
    directed = 0;
    check("no_fetch_17_20", {15'b0, hit_17_20}, 16'd0);
`ifdef CPU_UNDEF_HALT_EN
    check("halt_num_inst", num_inst, 16'd25);
`else
    check("skip_num_inst", num_inst, 16'd32);
`endif

    // Reset asserted while a fetch is outstanding; later strobes are ignored
    do_reset();
    repeat (3) bus_cycle();
    @(posedge clk); #1;
    check("midfetch_readM", {15'b0, readM}, 16'd1);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("midrst_readM", {15'b0, readM}, 16'd0);
    check("midrst_output_port", output_port, 16'd0);
    inputReady = 1'b1; #1 inputReady = 1'b0;
    check("midrst_num_inst", num_inst, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 inputReady = 1'b1; #1 inputReady = 1'b0;
    check("idle_strobe_num_inst", num_inst, 16'd0);
    repeat (6) bus_cycle();

    // Random programs
    for (int round = 0; round < 6; round++) begin
      for (int i = 0; i < 4096; i++) mem[i] = gen_instr();
      do_reset();
      repeat (120) bus_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 Parameter: WORD_SIZE, 16, data/address/instruction width; register file is 4 x WORD_SIZE.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge except instruction latch (REQ-012).
REQ-003 Port: reset_n  input  1  asynchronous active-low reset.
REQ-004 Port: readM  output  1  instruction-fetch request to memory.
REQ-005 Port: address  output  16  memory address; equals PC.
REQ-006 Port: data  inout  16  memory data bus; cpu only reads it and holds it at high-Z at all times.
REQ-007 Port: inputReady  input  1  memory pulse; data is valid while inputReady is high.
REQ-008 Port: num_inst  output  16  count of instructions fetched since reset.
REQ-009 Port: output_port  output  16  value written by the most recent WWD.

Function
REQ-010 Single-cycle operation: each clk period fetches, executes and retires one instruction.
REQ-011 On each rising clk edge, if an instruction is latched: commit the register write and load PC with next PC; then set readM=1 with address=PC (new value).
REQ-012 On rising edge of inputReady while readM=1: latch data as the instruction, set readM=0, num_inst += 1 (wraps at 16'hFFFF), mark the instruction latched.
REQ-013 WWD updates output_port at instruction latch time, so output_port and num_inst are stable at the following rising clk edge.
REQ-014 Instruction fields: opcode[15:12], rs[11:10], rt[9:8], rd[7:6], func[5:0], imm[7:0], target[11:0].
REQ-015 ADD (opcode 15, func 0): rd <= rs + rt, mod 2^16, no flags.
REQ-016 WWD (opcode 15, func 28): output_port <= rs; no register write.
REQ-017 ADI (opcode 4): rt <= rs + sign_extend(imm), mod 2^16.
REQ-018 LHI (opcode 6): rt <= {imm, 8'h00}.
REQ-019 JMP (opcode 9): next PC = {PC[15:12], target}; no register write.
REQ-020 All other instructions: next PC = PC + 1, wrapping at 16'hFFFF.
REQ-021 Register reads are combinational from the file state after the previous commit, so back-to-back dependent instructions see the updated value.
REQ-022 Unsupported opcode/func: behaviour is set by REQ-027/REQ-028.

Reset
REQ-023 While reset_n=0, regardless of clk: PC=0, all registers=0, readM=0, num_inst=0, output_port=0, no instruction latched.
REQ-024 First rising clk edge after reset_n rises: no commit; fetch starts at address 0.
REQ-025 Reset asserted mid-fetch abandons the fetch; a later inputReady pulse is ignored while readM=0.

Configuration
REQ-026 Macro CPU_UNDEF_HALT_EN selects the handling of unsupported opcode/func.
REQ-027 With CPU_UNDEF_HALT_EN defined: an unsupported instruction halts the CPU. readM stays 0, PC, registers and num_inst freeze, and only reset recovers.
REQ-028 Without CPU_UNDEF_HALT_EN: an unsupported instruction is a NOP (PC+1, no writes, num_inst still counts).

Verification
REQ-029 Reset, then LHI $0..$3 with imm 0..3, then WWD $0..$3 -> output_port 0, 256, 512, 768 when num_inst = 5, 6, 7, 8 at clk rising edge.
REQ-030 ADI $2,$0,4 and ADI $3,$1,-4 ($1=256), then WWD $2 and WWD $3 -> output_port 4 and 252 at num_inst 11 and 12.
REQ-031 ADD $3,$1,$2 then ADD $2,$0,$1, then WWD $2 and WWD $3 -> output_port 256 and 260 at num_inst 15 and 16.
REQ-032 JMP 21 at address 16 -> addresses 17-20 never fetched; next readM has address=21; num_inst increments by exactly 1 across the jump.
REQ-033 After the jump: LHI $0,0; ADI $0,$0,0; ADD $2,$3,$1; WWD $0..$3 -> output_port 0, 256, 516, 260 at num_inst 21-24.
REQ-034 Reset pulse mid-run, plus an undefined opcode (e.g. 16'hF03F) in each build -> outputs return to 0 and the PC restarts at 0. The opcode halts the CPU with CPU_UNDEF_HALT_EN and is skipped without it.
